// File: rtl/norm_shift_seq_if.sv
// Handshake bus for the mantissa normaliser: raw mantissa/exponent request in,
// normalised result plus shift status out.
interface norm_shift_seq_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  localparam int CNT_W = $clog2(MANT_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant_in;
  logic [EXP_W-1:0]  exp_in;
  logic              cout;
  logic              op;

  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] mant_out;
  logic [EXP_W-1:0]  exp_out;
  logic [CNT_W-1:0]  shift_cnt;
  logic              shift_right;
  logic              zero;
  logic              underflow;
  logic              overflow;

  modport master (
    output in_valid, mant_in, exp_in, cout, op, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, shift_cnt,
           shift_right, zero, underflow, overflow
  );

  modport slave (
    input  in_valid, mant_in, exp_in, cout, op, out_ready,
    output in_ready, out_valid, mant_out, exp_out, shift_cnt,
           shift_right, zero, underflow, overflow
  );
endinterface

// File: rtl/norm_shift_seq.sv
// Multi-cycle mantissa normaliser: one-step right shift on add carry-out, or
// iterative left shift of up to STEP positions per cycle until the MSB is set.
module norm_shift_seq #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int STEP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  norm_shift_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(MANT_W + 1);
  // Common width for min(lz, STEP, exp) so no operand is truncated.
  localparam int SW    = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_OVF = EXP_MAX - EXP_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sr_q, sr_d;
  logic              zero_q, zero_d;
  logic              uf_q, uf_d;
  logic              of_q, of_d;

  logic [SW-1:0]     s_w;
  logic [EXP_W:0]    exp_inc;
  logic [EXP_W:0]    exp_sub;
  logic [MANT_W-1:0] mant_sh;

  function automatic logic [CNT_W-1:0] lzc(input logic [MANT_W-1:0] m);
    lzc = CNT_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++)
      if (m[i]) lzc = CNT_W'(MANT_W - 1 - i);
  endfunction

  // Per-cycle shift amount: never past the leading one, STEP, or exponent 0.
  always_comb begin
    s_w = SW'(lzc(mant_q));
    if (SW'(STEP) < s_w)  s_w = SW'(STEP);
    if (SW'(exp_q) < s_w) s_w = SW'(exp_q);
  end

  assign exp_inc = {1'b0, bus.exp_in} + (EXP_W+1)'(1);
  assign exp_sub = {1'b0, exp_q} - (EXP_W+1)'(s_w);
  assign mant_sh = mant_q << s_w;

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    of_d    = of_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d   = 1'b0;
          zero_d = 1'b0;
          uf_d   = 1'b0;
          of_d   = 1'b0;
          cnt_d  = '0;
          mant_d = bus.mant_in;
          exp_d  = bus.exp_in;
          state_d = DONE;
          if (bus.cout && !bus.op) begin
            sr_d  = 1'b1;
            cnt_d = CNT_W'(1);
            if (bus.exp_in >= EXP_OVF) begin
              mant_d = '0;
              exp_d  = EXP_MAX;
              of_d   = 1'b1;
            end else begin
              mant_d = {1'b1, bus.mant_in[MANT_W-1:1]};
              exp_d  = EXP_W'(exp_inc);
            end
          end else if (bus.mant_in == '0) begin
            exp_d  = '0;
            zero_d = 1'b1;
          end else if (!bus.mant_in[MANT_W-1]) begin
            // Exponent already at 0 cannot absorb any left shift.
            if (bus.exp_in == '0) uf_d = 1'b1;
            else                  state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_d = mant_sh;
        exp_d  = EXP_W'(exp_sub);
        cnt_d  = cnt_q + CNT_W'(s_w);
        if (mant_sh[MANT_W-1] || exp_sub == '0) begin
          state_d = DONE;
          uf_d    = !mant_sh[MANT_W-1];
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= 1'b0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.mant_out    = mant_q;
  assign bus.exp_out     = exp_q;
  assign bus.shift_cnt   = cnt_q;
  assign bus.shift_right = sr_q;
  assign bus.zero        = zero_q;
  assign bus.underflow   = uf_q;
  assign bus.overflow    = of_q;
endmodule

// File: tb/tb_norm_shift_seq.sv
// Randomised bench for norm_shift_seq against a closed-form normalisation model.
module tb_norm_shift_seq;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    logic [23:0] m;
    logic [7:0]  e;
    logic [4:0]  c;
    logic        sr, z, uf, of;
    int          lat;
  } res_t;

  res_t q[$];

  norm_shift_seq_if #(.MANT_W(24), .EXP_W(8)) bus();

  norm_shift_seq #(.MANT_W(24), .EXP_W(8), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Result straight from the normalisation rules: total left shift is
  // min(leading zeros, exponent), taken STEP=4 positions per cycle.
  function automatic res_t model(logic [23:0] m, logic [7:0] e, logic co, logic o);
    res_t r;
    int lz, sh;
    r = '{default: 0};
    if (co && !o) begin
      r.sr = 1'b1;
      r.c  = 5'd1;
      if (e >= 8'd254) begin
        r.e  = 8'hFF;
        r.m  = '0;
        r.of = 1'b1;
      end else begin
        r.m = (m >> 1) | 24'h800000;
        r.e = 8'(int'(e) + 1);
      end
    end else if (m == 0) begin
      r.z = 1'b1;
    end else begin
      lz = 0;
      while (!m[23 - lz]) lz++;
      sh    = (lz < int'(e)) ? lz : int'(e);
      r.m   = m << sh;
      r.e   = 8'(int'(e) - sh);
      r.c   = 5'(sh);
      r.uf  = !r.m[23];
      r.lat = (sh + 3) / 4;
    end
    return r;
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("mant_out",    bus.mant_out,    q[0].m);
        check("exp_out",     bus.exp_out,     q[0].e);
        check("shift_cnt",   bus.shift_cnt,   q[0].c);
        check("shift_right", bus.shift_right, q[0].sr);
        check("zero",        bus.zero,        q[0].z);
        check("underflow",   bus.underflow,   q[0].uf);
        check("overflow",    bus.overflow,    q[0].of);
        check("in_ready_busy", bus.in_ready,  0);
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic accept(input logic [23:0] m, input logic [7:0] e,
                        input logic co, input logic o, output int lat);
    int n = 0;
    res_t r;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.mant_in  = m;
    bus.exp_in   = e;
    bus.cout     = co;
    bus.op       = o;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    r = model(m, e, co, o);
    q.push_back(r);
    lat = r.lat;
  endtask

  task automatic complete(input int lat, input int hold, input bit noise);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      if (noise) begin
        bus.in_valid  = 1'b1;
        bus.mant_in   = 24'($urandom);
        bus.exp_in    = 8'($urandom);
        bus.out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (n >= 100) check("out_valid_timeout", 0, 1);
    check("latency", n, lat);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic txn(input logic [23:0] m, input logic [7:0] e, input logic co,
                     input logic o, input int hold, input bit noise);
    int lat;
    accept(m, e, co, o, lat);
    complete(lat, hold, noise);
  endtask

  task automatic pin(input string nm, input res_t r, input logic [23:0] m,
                     input logic [7:0] e, input logic [4:0] c, input logic [3:0] fl,
                     input int lat);
    check({nm, "_m"},   r.m, m);
    check({nm, "_e"},   r.e, e);
    check({nm, "_c"},   r.c, c);
    check({nm, "_fl"},  {r.sr, r.z, r.uf, r.of}, fl);
    check({nm, "_lat"}, r.lat, lat);
  endtask

  initial begin
    int lat;
    logic [23:0] m;
    logic [7:0]  e;
    bus.in_valid = 0; bus.mant_in = 0; bus.exp_in = 0;
    bus.cout = 0; bus.op = 0; bus.out_ready = 0;
    rst_n = 1'b0;
    #12;
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mant",      bus.mant_out, 0);
    check("rst_exp",       bus.exp_out, 0);
    check("rst_cnt",       bus.shift_cnt, 0);
    check("rst_flags", {bus.shift_right, bus.zero, bus.underflow, bus.overflow}, 0);

    // Flags are {shift_right, zero, underflow, overflow}.
    pin("pin_pass",  model(24'h800000, 8'h80, 0, 0), 24'h800000, 8'h80, 5'd0,  4'b0000, 0);
    pin("pin_deep",  model(24'h000001, 8'h80, 1, 1), 24'h800000, 8'h69, 5'd23, 4'b0000, 6);
    pin("pin_carry", model(24'h400001, 8'h10, 1, 0), 24'hA00000, 8'h11, 5'd1,  4'b1000, 0);
    pin("pin_ovf",   model(24'h400001, 8'hFE, 1, 0), 24'h000000, 8'hFF, 5'd1,  4'b1001, 0);
    pin("pin_zero",  model(24'h000000, 8'h40, 0, 0), 24'h000000, 8'h00, 5'd0,  4'b0100, 0);
    pin("pin_uf",    model(24'h000100, 8'h05, 0, 1), 24'h002000, 8'h00, 5'd5,  4'b0010, 2);

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(24'h800000, 8'h80, 0, 0, 5, 0);
    txn(24'h000001, 8'h80, 1, 1, 0, 1);
    @(posedge clk); #1;
    check("idle_no_out", bus.out_valid, 0);
    txn(24'h400001, 8'h10, 1, 0, 0, 0);
    txn(24'h400001, 8'hFE, 1, 0, 1, 0);
    txn(24'h400001, 8'hFF, 1, 0, 0, 0);
    txn(24'h000000, 8'h40, 0, 0, 0, 0);
    txn(24'h000100, 8'h05, 0, 1, 2, 0);
    txn(24'h000100, 8'h00, 0, 0, 0, 0);
    txn(24'h000030, 8'h03, 1, 1, 0, 0);

    // Abort mid-shift: everything returns to reset values at once.
    accept(24'h000001, 8'h80, 0, 1, lat);
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready",  bus.in_ready, 1);
    check("abort_mant",      bus.mant_out, 0);
    check("abort_exp",       bus.exp_out, 0);
    check("abort_cnt",       bus.shift_cnt, 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_idle", bus.out_valid, 0);
    txn(24'h0003C0, 8'h20, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      m = 24'($urandom) & (24'hFFFFFF >> $urandom_range(0, 24));
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom);
        1:       e = 8'($urandom_range(252, 255));
        default: e = 8'($urandom_range(0, 30));
      endcase
      txn(m, e, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    @(posedge clk); #1;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
